// File: rtl/savestate_ui_ctrl_if.sv
// Request/acknowledge channel between the savestate UI controller and the savestate engine.
interface savestate_ui_ctrl_if #(
    parameter int unsigned SLOT_BITS = 2
);
    logic                 ss_req_save;
    logic                 ss_req_load;
    logic [SLOT_BITS-1:0] ss_req_slot;
    logic                 ss_busy;
    logic                 ss_ack;

    modport master (
        output ss_req_save, ss_req_load, ss_req_slot, ss_busy,
        input  ss_ack
    );

    modport slave (
        input  ss_req_save, ss_req_load, ss_req_slot, ss_busy,
        output ss_ack
    );
endinterface

// File: rtl/savestate_ui_ctrl.sv
// Savestate UI: slot selection, save/load request handshake with busy guard and ack timeout, info text.
// Optional save confirmation (ARM state) is enabled by defining SS_SAVE_CONFIRM_EN.
module savestate_ui_ctrl #(
    parameter int unsigned SLOT_COUNT        = 4,
    parameter int unsigned SLOT_BITS         = 2,
    parameter int unsigned INFO_TIMEOUT_BITS = 25,
    parameter int unsigned ACK_TIMEOUT_BITS  = 24,
    parameter int unsigned SLOT_WRAP         = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [10:0]          ps2_key,
    input  logic                 allow_ss,
    input  logic                 joySS,
    input  logic                 joyRight,
    input  logic                 joyLeft,
    input  logic                 joyUp,
    input  logic                 joyDown,
    input  logic                 joyStart,
    input  logic [SLOT_BITS-1:0] status_slot,
    input  logic [1:0]           OSD_saveload,
    savestate_ui_ctrl_if.master  ss,
    output logic                 info_req,
    output logic [7:0]           info,
    output logic                 statusUpdate,
    output logic [SLOT_BITS-1:0] selected_slot
);
    localparam logic [SLOT_BITS-1:0] SLOT_MAX = SLOT_BITS'(SLOT_COUNT - 1);
    localparam int unsigned          AMSB     = ACK_TIMEOUT_BITS - 1;
    localparam int unsigned          HMSB     = INFO_TIMEOUT_BITS - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1
`ifdef SS_SAVE_CONFIRM_EN
        , ST_ARM = 2'd2
`endif
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [SLOT_BITS-1:0]    r_slot, w_slot_nxt, r_status_prev, r_req_slot, w_req_slot_nxt;
    logic [SLOT_BITS-1:0]    w_status_clamp, w_fkey_slot;
    logic                    r_alt, r_key_prev;
    logic [3:0]              r_joy_prev;
    logic [1:0]              r_osd_prev;
    logic [AMSB:0]           r_ack_cnt, w_ack_cnt_nxt, w_ack_inc;
    logic [HMSB:0]           r_help_cnt, w_help_cnt_nxt, w_help_inc;
    logic                    r_req_save, r_req_load, r_busy, r_info_req, r_status_upd;
    logic                    w_req_save_nxt, w_req_load_nxt, w_busy_nxt, w_info_req_nxt, w_start;
    logic [7:0]              r_info, w_info_nxt;
    logic [1:0]              w_fkey_idx;
    logic                    w_fkey_vld, w_key_evt, w_kb_sel;
    logic                    w_right_edge, w_left_edge, w_down_edge, w_up_edge;
    logic                    w_save, w_load, w_action, w_slot_chg, w_any_evt, w_ack_tmo, w_help_fire;
    logic                    w_unused_key;
`ifdef SS_SAVE_CONFIRM_EN
    logic [HMSB:0]           r_arm_cnt, w_arm_cnt_nxt;
    logic                    w_arm_expire;
    assign w_arm_expire = &r_arm_cnt;
`endif

    assign w_unused_key = ps2_key[8];
    assign w_right_edge = joyRight & ~r_joy_prev[0];
    assign w_left_edge  = joyLeft  & ~r_joy_prev[1];
    assign w_down_edge  = joyDown  & ~r_joy_prev[2];
    assign w_up_edge    = joyUp    & ~r_joy_prev[3];
    assign w_key_evt    = ps2_key[10] & ~r_key_prev;

    // F1..F4 scancodes map to slots 0..3; slots beyond SLOT_COUNT are ignored
    always_comb begin
        w_fkey_vld = 1'b1;
        w_fkey_idx = 2'd0;
        case (ps2_key[7:0])
            8'h05:   w_fkey_idx = 2'd0;
            8'h06:   w_fkey_idx = 2'd1;
            8'h04:   w_fkey_idx = 2'd2;
            8'h0C:   w_fkey_idx = 2'd3;
            default: w_fkey_vld = 1'b0;
        endcase
    end

    assign w_fkey_slot    = SLOT_BITS'(w_fkey_idx);
    assign w_kb_sel       = allow_ss & w_key_evt & ps2_key[9] & w_fkey_vld & (32'(w_fkey_idx) < SLOT_COUNT);
    assign w_status_clamp = (32'(status_slot) >= SLOT_COUNT) ? SLOT_MAX : status_slot;

    // Slot update: OSD, then keyboard, then gamepad; the last writer wins
    always_comb begin
        w_slot_nxt = r_slot;
        if (allow_ss) begin
            if (status_slot != r_status_prev) w_slot_nxt = w_status_clamp;
            if (w_kb_sel)                     w_slot_nxt = w_fkey_slot;
            if (joySS && w_right_edge)
                w_slot_nxt = (r_slot == SLOT_MAX) ? ((SLOT_WRAP != 0) ? '0 : SLOT_MAX)
                                                  : r_slot + SLOT_BITS'(1);
            else if (joySS && w_left_edge)
                w_slot_nxt = (r_slot == '0) ? ((SLOT_WRAP != 0) ? SLOT_MAX : '0)
                                            : r_slot - SLOT_BITS'(1);
        end
    end

    assign w_slot_chg  = (w_slot_nxt != r_slot);
    assign w_save      = allow_ss & ((w_kb_sel & r_alt) | (joySS & joyStart & w_down_edge)
                                     | (OSD_saveload[0] & ~r_osd_prev[0]));
    assign w_load      = allow_ss & ~w_save & ((w_kb_sel & ~r_alt) | (joySS & joyStart & w_up_edge)
                                               | (OSD_saveload[1] & ~r_osd_prev[1]));
    assign w_action    = w_save | w_load;
    assign w_any_evt   = w_slot_chg | w_action;
    assign w_ack_inc   = r_ack_cnt + ACK_TIMEOUT_BITS'(1);
    assign w_ack_tmo   = w_ack_inc[AMSB];
    assign w_help_inc  = r_help_cnt + INFO_TIMEOUT_BITS'(1);
    assign w_help_fire = allow_ss & joySS & ~w_any_evt & w_help_inc[HMSB];

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef SS_SAVE_CONFIRM_EN
                if (w_save)      w_state_nxt = ST_ARM;
                else if (w_load) w_state_nxt = ST_PEND;
`else
                if (w_action)    w_state_nxt = ST_PEND;
`endif
            end
            ST_PEND: if (ss.ss_ack || w_ack_tmo) w_state_nxt = ST_IDLE;
`ifdef SS_SAVE_CONFIRM_EN
            ST_ARM: begin
                if (w_slot_chg || w_load) w_state_nxt = ST_IDLE;
                else if (w_save)          w_state_nxt = ST_PEND;
                else if (w_arm_expire)    w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Info is written lowest priority first: help < slot change < action < busy/timeout
    always_comb begin
        w_req_save_nxt = r_req_save;
        w_req_load_nxt = r_req_load;
        w_req_slot_nxt = r_req_slot;
        w_busy_nxt     = r_busy;
        w_ack_cnt_nxt  = '0;
        w_help_cnt_nxt = '0;
        w_info_req_nxt = 1'b0;
        w_info_nxt     = r_info;
        w_start        = 1'b0;
`ifdef SS_SAVE_CONFIRM_EN
        w_arm_cnt_nxt  = '0;
`endif
        if (allow_ss && joySS && !w_any_evt && !w_help_fire) w_help_cnt_nxt = w_help_inc;
        if (w_help_fire) begin
            w_info_req_nxt = 1'b1;
            w_info_nxt     = 8'h01;
        end
        if (w_slot_chg) begin
            w_info_req_nxt = 1'b1;
            w_info_nxt     = 8'h02 + 8'(w_slot_nxt);
        end
        case (r_state)
            ST_IDLE: begin
`ifdef SS_SAVE_CONFIRM_EN
                if (w_save) begin
                    w_info_req_nxt = 1'b1;
                    w_info_nxt     = 8'h20 + 8'(w_slot_nxt);
                end else if (w_load) begin
                    w_start = 1'b1;
                end
`else
                w_start = w_action;
`endif
            end
            ST_PEND: begin
                if (w_action) begin
                    w_info_req_nxt = 1'b1;
                    w_info_nxt     = 8'h7F;
                end
                if (ss.ss_ack || w_ack_tmo) begin
                    w_req_save_nxt = 1'b0;
                    w_req_load_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                    if (!ss.ss_ack) begin
                        w_info_req_nxt = 1'b1;
                        w_info_nxt     = 8'h7E;
                    end
                end else begin
                    w_ack_cnt_nxt = w_ack_inc;
                end
            end
`ifdef SS_SAVE_CONFIRM_EN
            ST_ARM: begin
                if (!w_slot_chg && !w_load) begin
                    if (w_save) w_start = 1'b1;
                    else        w_arm_cnt_nxt = r_arm_cnt + INFO_TIMEOUT_BITS'(1);
                end
            end
`endif
            default: ;
        endcase
        if (w_start) begin
            w_req_save_nxt = w_save;
            w_req_load_nxt = w_load;
            w_req_slot_nxt = w_slot_nxt;
            w_busy_nxt     = 1'b1;
            w_info_req_nxt = 1'b1;
            w_info_nxt     = 8'h40 + 8'({w_slot_nxt, w_load});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot        <= '0;
            r_status_prev <= '0;
            r_joy_prev    <= '0;
            r_key_prev    <= 1'b0;
            r_osd_prev    <= '0;
            r_alt         <= 1'b0;
            r_ack_cnt     <= '0;
            r_help_cnt    <= '0;
            r_req_save    <= 1'b0;
            r_req_load    <= 1'b0;
            r_req_slot    <= '0;
            r_busy        <= 1'b0;
            r_info_req    <= 1'b0;
            r_info        <= '0;
            r_status_upd  <= 1'b0;
`ifdef SS_SAVE_CONFIRM_EN
            r_arm_cnt     <= '0;
`endif
        end else begin
            r_slot        <= w_slot_nxt;
            r_status_prev <= status_slot;
            r_joy_prev    <= {joyUp, joyDown, joyLeft, joyRight};
            r_key_prev    <= ps2_key[10];
            r_osd_prev    <= OSD_saveload;
            if (w_key_evt && ps2_key[7:0] == 8'h11) r_alt <= ps2_key[9];
            r_ack_cnt     <= w_ack_cnt_nxt;
            r_help_cnt    <= w_help_cnt_nxt;
            r_req_save    <= w_req_save_nxt;
            r_req_load    <= w_req_load_nxt;
            r_req_slot    <= w_req_slot_nxt;
            r_busy        <= w_busy_nxt;
            r_info_req    <= w_info_req_nxt;
            r_info        <= w_info_nxt;
            r_status_upd  <= w_slot_chg;
`ifdef SS_SAVE_CONFIRM_EN
            r_arm_cnt     <= w_arm_cnt_nxt;
`endif
        end
    end

    assign ss.ss_req_save = r_req_save;
    assign ss.ss_req_load = r_req_load;
    assign ss.ss_req_slot = r_req_slot;
    assign ss.ss_busy     = r_busy;
    assign info_req       = r_info_req;
    assign info           = r_info;
    assign statusUpdate   = r_status_upd;
    assign selected_slot  = r_slot;
endmodule
